// File: rtl/adam_obi_sram_port_pkg.sv
// Shared types and sizes for the OBI SRAM port.
// Stands in for the fabric config set (address/data/strobe types, fabric credit depth).
package adam_obi_sram_port_pkg;

    localparam int ADDR_WIDTH    = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int STRB_WIDTH    = DATA_WIDTH / 8;
    localparam int FAB_MAX_TRANS = 4;

    typedef logic [ADDR_WIDTH-1:0] ADDR_T;
    typedef logic [DATA_WIDTH-1:0] DATA_T;
    typedef logic [STRB_WIDTH-1:0] STRB_T;

endpackage

// File: rtl/adam_obi_sram_rfifo.sv
// Generic synchronous FIFO with registered storage, no fall-through,
// occupancy-count based full/empty and modulo-DEPTH pointer wrap.
module adam_obi_sram_rfifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic empty_o,
    output logic full_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULLC = CW'(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULLC);
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is legal only when the head leaves this cycle
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? T'('0) : mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
        if (do_pop)  rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
        if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
        if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/adam_obi_sram_port.sv
// OBI slave front-end for a fixed-latency single-port SRAM macro with
// credit-limited grants, pause handshake and a decoupling response FIFO.
module adam_obi_sram_port
    import adam_obi_sram_port_pkg::*;
#(
    parameter int MAX_TRANS      = FAB_MAX_TRANS,
    parameter int MEM_LATENCY    = 1,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      pause_req_i,
    output logic                      pause_ack_o,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  ADDR_T                     addr_i,
    input  logic                      we_i,
    input  STRB_T                     be_i,
    input  DATA_T                     wdata_i,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output DATA_T                     rdata_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output STRB_T                     mem_be_o,
    output DATA_T                     mem_wdata_o,
    input  DATA_T                     mem_rdata_i
);

    localparam int OFF = $clog2(DATA_WIDTH / 8);
    localparam int CW  = $clog2(MAX_TRANS + 1);
    localparam int L   = MEM_LATENCY;
    localparam logic [CW-1:0] CMAX = CW'(MAX_TRANS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [L-1:0]  vld_q, vld_d;
    logic [L-1:0]  we_q, we_d;
    logic          ack_q;
    logic          pop;
    logic          empty;
    logic          unused_full;
    logic          unused_addr;
    DATA_T         push_data;

    assign gnt_o     = req_i && !pause_req_i && (cnt_q < CMAX);
    assign mem_req_o = req_i && gnt_o;
    assign rvalid_o  = !empty;
    assign pop       = rvalid_o && rready_i;
    assign pause_ack_o = ack_q;
    assign unused_addr = ^{addr_i[ADDR_WIDTH-1:OFF+MEM_ADDR_WIDTH],
                           addr_i[OFF-1:0]};

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            mem_we_o    = we_i;
            mem_addr_o  = addr_i[OFF +: MEM_ADDR_WIDTH];
            mem_be_o    = we_i ? be_i : '0;
            mem_wdata_o = wdata_i;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (mem_req_o && !pop) cnt_d = cnt_q + CW'(1);
        if (!mem_req_o && pop) cnt_d = cnt_q - CW'(1);
    end

    // Tail of the latency line lines up with mem_rdata of that access
    always_comb begin
        vld_d    = vld_q << 1;
        we_d     = we_q << 1;
        vld_d[0] = mem_req_o;
        we_d[0]  = mem_req_o && we_i;
    end

    assign push_data = we_q[L-1] ? DATA_T'('0) : mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            vld_q <= '0;
            we_q  <= '0;
            ack_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            we_q  <= we_d;
            ack_q <= pause_req_i && (cnt_q == '0) && (cnt_d == '0);
        end
    end

    adam_obi_sram_rfifo #(
        .DEPTH (MAX_TRANS),
        .T     (DATA_T)
    ) i_rfifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (vld_q[L-1]),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (rdata_o),
        .empty_o (empty),
        .full_o  (unused_full)
    );

endmodule
